// File: rtl/lightsout_pkg.sv
// Shared constants and FSM state type for the Lights Out display link.
package lightsout_pkg;

   localparam int unsigned GRID_W      = 5;
   localparam int unsigned BOARD_CELLS = GRID_W * GRID_W;
   localparam int unsigned DEF_CLK_DIV = 4;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH
   } state_t;

endpackage

// File: rtl/lightsout_tick_gen.sv
// Clock divider for the serial link: tick marks the last clk of each SCLK half-period.
module lightsout_tick_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_cnt;

   assign tick = (div_cnt == DW'(CLK_DIV - 1));

   // Divider counter: synchronous clear wins, wraps to zero on tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (clr) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/lightsout_board_shifter.sv
// Snapshots the board and shifts it MSB-first into a 74HC595-style chain,
// then strobes the storage latch for one SCLK half-period.
module lightsout_board_shifter
   import lightsout_pkg::*;
#(
   parameter int unsigned CELLS   = BOARD_CELLS,
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [CELLS-1:0] board_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             sclk_o,
   output logic             sdata_o,
   output logic             latch_o
);

   localparam int unsigned BW = $clog2(CELLS);

   state_t           state, state_nxt;
   logic [CELLS-2:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic             tick;
   logic             capture;
   logic             last_bit;

   assign capture  = ena && start_i && (state == IDLE);
   assign last_bit = (bit_cnt == BW'(CELLS - 1));

   lightsout_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (capture || !ena),
      .en   (state != IDLE),
      .tick (tick)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; dropping ena abandons the frame from any state.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (capture) state_nxt = SHIFT;
         SHIFT:   if (tick && sclk_o && last_bit) state_nxt = LATCH;
         LATCH:   if (tick) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (!ena) begin
         state_nxt = IDLE;
      end
   end

   // Datapath and registered outputs. The MSB goes straight to sdata_o on
   // capture, so the shift register only holds the remaining CELLS-1 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         sclk_o  <= 1'b0;
         sdata_o <= 1'b0;
         latch_o <= 1'b0;
      end else if (!ena) begin
         shreg   <= '0;
         bit_cnt <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         sclk_o  <= 1'b0;
         sdata_o <= 1'b0;
         latch_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  shreg   <= board_i[CELLS-2:0];
                  sdata_o <= board_i[CELLS-1];
                  sclk_o  <= 1'b0;
                  bit_cnt <= '0;
                  busy_o  <= 1'b1;
               end
            end
            SHIFT: begin
               if (tick) begin
                  if (!sclk_o) begin
                     sclk_o <= 1'b1;
                  end else begin
                     sclk_o <= 1'b0;
                     if (last_bit) begin
                        latch_o <= 1'b1;
                        sdata_o <= 1'b0;
                     end else begin
                        sdata_o <= shreg[CELLS-2];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
            end
            LATCH: begin
               if (tick) begin
                  latch_o <= 1'b0;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lightsout_board_shifter.sv
// Self-checking bench: a cycle-position model of the serial frame is compared
// against two DUTs (CLK_DIV=4 and CLK_DIV=1) every cycle, plus directed checks.
module tb_lightsout_board_shifter;

   localparam int C  = 25;
   localparam int D0 = 4;
   localparam int D1 = 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   ena_v, start_v;
   logic [1:0]   busy_v, done_v, sclk_v, sdata_v, latch_v;
   logic [C-1:0] board_v [2];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   lightsout_board_shifter #(.CELLS(C), .CLK_DIV(D0)) dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena_v[0]), .board_i(board_v[0]),
      .start_i(start_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]),
      .sclk_o(sclk_v[0]), .sdata_o(sdata_v[0]), .latch_o(latch_v[0])
   );

   lightsout_board_shifter #(.CELLS(C), .CLK_DIV(D1)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena_v[1]), .board_i(board_v[1]),
      .start_i(start_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]),
      .sclk_o(sclk_v[1]), .sdata_o(sdata_v[1]), .latch_o(latch_v[1])
   );

   function automatic int div_of(input int d);
      return (d == 0) ? D0 : D1;
   endfunction

   function automatic logic [4:0] outs(input int d);
      return {busy_v[d], done_v[d], sclk_v[d], sdata_v[d], latch_v[d]};
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Model: a frame is just "captured word + clocks elapsed since acceptance".
   bit           m_act  [2];
   bit           m_done [2];
   int           m_p    [2];
   logic [C-1:0] m_frame[2];

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         int dv;
         dv = div_of(d);
         if (!rst_n || !ena_v[d]) begin
            m_act[d]  = 1'b0;
            m_done[d] = 1'b0;
         end else if (m_act[d]) begin
            m_p[d] = m_p[d] + 1;
            if (m_p[d] == 2 * C * dv + dv) begin
               m_act[d]  = 1'b0;
               m_done[d] = 1'b1;
            end
         end else begin
            m_done[d] = 1'b0;
            if (start_v[d]) begin
               m_act[d]   = 1'b1;
               m_p[d]     = 0;
               m_frame[d] = board_v[d];
            end
         end
      end
   end

   // {busy, done, sclk, sdata, latch} implied by position within the frame.
   function automatic logic [4:0] expect_out(input int d);
      int dv;
      int b;
      dv = div_of(d);
      if (!m_act[d]) return {1'b0, m_done[d], 3'b000};
      if (m_p[d] < 2 * C * dv) begin
         b = m_p[d] / (2 * dv);
         return {1'b1, 1'b0, 1'(((m_p[d] / dv) % 2)), m_frame[d][C-1-b], 1'b0};
      end
      return 5'b10001;
   endfunction

   // Receiver-side observations.
   logic [1:0]   sclk_prev = '0;
   int           edges     [2];
   int           latch_cyc [2];
   int           done_cnt  [2];
   int           last_done [2];
   logic [C-1:0] bits      [2];
   int           done_at   [$];

   always @(posedge clk) begin
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("outputs_dut%0d", d), outs(d), expect_out(d));
         if (sclk_v[d] && !sclk_prev[d]) begin
            edges[d]++;
            bits[d] = {bits[d][C-2:0], sdata_v[d]};
         end
         sclk_prev[d] = sclk_v[d];
         if (latch_v[d]) latch_cyc[d]++;
         if (done_v[d]) begin
            done_cnt[d]++;
            last_done[d] = cyc;
            if (d == 0) done_at.push_back(cyc);
         end
      end
   end

   task automatic clear_mon(input int d);
      edges[d]     = 0;
      latch_cyc[d] = 0;
      done_cnt[d]  = 0;
      bits[d]      = '0;
      if (d == 0) done_at.delete();
   endtask

   // One frame; optionally scramble board_i or pulse start_i mid-frame.
   task automatic run_frame(input int d, input logic [C-1:0] board,
                            input bit scramble, input bit pulse, input string tag);
      int acc;
      int n;
      clear_mon(d);
      board_v[d] = board;
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      acc = cyc;
      n = 0;
      while (done_cnt[d] == 0 && n < 3000) begin
         @(negedge clk);
         n++;
         if (scramble && n == 30) board_v[d] = ~board;
         if (pulse) start_v[d] = (n == 30);
      end
      start_v[d] = 1'b0;
      if (done_cnt[d] == 0) begin
         chk({tag, "_done_timeout"}, 0, 1);
      end else begin
         chk({tag, "_latency"}, last_done[d] - acc + 1, (d == 0) ? 205 : 52);
      end
      repeat (10) @(negedge clk);
      chk({tag, "_bits"}, bits[d], board);
      chk({tag, "_edges"}, edges[d], 25);
      chk({tag, "_latch_cycles"}, latch_cyc[d], (d == 0) ? 4 : 1);
      chk({tag, "_done_count"}, done_cnt[d], 1);
   endtask

   task automatic held_test();
      int acc;
      int n;
      clear_mon(0);
      board_v[0] = 25'h0123456;
      start_v[0] = 1'b1;
      @(negedge clk);
      acc = cyc;
      n = 0;
      while (done_cnt[0] < 3 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      start_v[0] = 1'b0;
      if (done_at.size() != 3) begin
         chk("held_done_count", done_at.size(), 3);
      end else begin
         chk("held_first_latency", done_at[0] - acc + 1, 205);
         chk("held_interval_1", done_at[1] - done_at[0], 205);
         chk("held_interval_2", done_at[2] - done_at[1], 205);
      end
      repeat (250) @(negedge clk);
      chk("held_no_extra_frame", done_cnt[0], 3);
      chk("held_edges", edges[0], 75);
   endtask

   task automatic reset_test();
      clear_mon(0);
      board_v[0] = 25'h1ABCDEF;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (30) @(negedge clk);
      chk("reset_pre_busy", busy_v[0], 1);
      rst_n = 1'b0;
      #1;
      chk("reset_async_outputs", outs(0), 5'b00000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (250) @(negedge clk);
      chk("reset_no_done", done_cnt[0], 0);
      chk("reset_no_latch", latch_cyc[0], 0);
   endtask

   task automatic ena_test(input int d);
      int dv;
      dv = div_of(d);
      clear_mon(d);
      board_v[d] = 25'h1FFFFFF;
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      repeat (20 * dv) @(negedge clk);
      ena_v[d] = 1'b0;
      @(negedge clk);
      chk($sformatf("abort_outputs_dut%0d", d), outs(d), 5'b00000);
      repeat (3) @(negedge clk);
      ena_v[d] = 1'b1;
      repeat (2 * C * dv + dv + 10) @(negedge clk);
      chk($sformatf("abort_no_done_dut%0d", d), done_cnt[d], 0);
      chk($sformatf("abort_no_latch_dut%0d", d), latch_cyc[d], 0);
      chk($sformatf("abort_edges_dut%0d", d), edges[d], 10);
      run_frame(d, 25'h1555555, 1'b0, 1'b0, $sformatf("after_abort_dut%0d", d));
   endtask

   initial begin
      ena_v      = '0;
      start_v    = '0;
      board_v[0] = '0;
      board_v[1] = '0;
      clear_mon(0);
      clear_mon(1);
      repeat (2) @(negedge clk);
      chk("reset_state_dut0", outs(0), 5'b00000);
      chk("reset_state_dut1", outs(1), 5'b00000);
      rst_n = 1'b1;
      ena_v = 2'b11;
      @(negedge clk);

      run_frame(0, 25'h1555555, 1'b0, 1'b0, "alt_pattern");
      run_frame(0, 25'h0000001, 1'b1, 1'b0, "last_bit_only");
      run_frame(0, 25'h1000000, 1'b1, 1'b0, "first_bit_only");
      run_frame(0, 25'h0ABCDEF, 1'b0, 1'b1, "start_while_busy");
      held_test();
      reset_test();
      ena_test(0);
      ena_test(1);
      run_frame(1, 25'h0000001, 1'b1, 1'b1, "div1_last_bit");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
